// File: rtl/i2c_frame_decoder.sv
// I2C front end: synchronizes raw SCL/SDA, decodes START/STOP/Sr, captures each byte plus ACK and
// writes one record per byte to the capture RAM. Optional input filter: I2CD_GLITCH_FILTER_EN.
module i2c_frame_decoder #(
    parameter int unsigned AW       = 8,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             scl,
    input  logic             sda,
    input  logic             clr,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [7:0]       wr_data,
    output logic [1:0]       wr_tag,
    output logic             full,
    output logic             busy,
    output logic [CNT_W-1:0] start_cnt,
    output logic [CNT_W-1:0] stop_cnt,
    output logic [7:0]       frag_cnt
);

    typedef enum logic [1:0] {StIdle, StData, StAck} state_e;

    logic scl_m, sda_m, scl_s, sda_s;
    logic scl_v, sda_v, scl_d, sda_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            scl_m <= 1'b1;
            sda_m <= 1'b1;
            scl_s <= 1'b1;
            sda_s <= 1'b1;
            scl_d <= 1'b1;
            sda_d <= 1'b1;
        end else begin
            scl_m <= scl;
            sda_m <= sda;
            scl_s <= scl_m;
            sda_s <= sda_m;
            scl_d <= scl_v;
            sda_d <= sda_v;
        end
    end

`ifdef I2CD_GLITCH_FILTER_EN
    localparam int unsigned FCW = $clog2(FILT_LEN + 1);

    logic [1:0]     raw;
    logic [1:0]     filt_q;
    logic [FCW-1:0] fcnt_q [2];

    assign raw = {sda_s, scl_s};

    // Output follows the input only after FILT_LEN consecutive differing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            filt_q    <= 2'b11;
            fcnt_q[0] <= '0;
            fcnt_q[1] <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (raw[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FCW'(FILT_LEN - 1)) begin
                    filt_q[i] <= raw[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign scl_v = filt_q[0];
    assign sda_v = filt_q[1];
`else
    logic unused_filt_len;
    assign unused_filt_len = (FILT_LEN == 0);
    assign scl_v = scl_s;
    assign sda_v = sda_s;
`endif

    logic rise, start_evt, stop_evt;
    assign rise      = scl_v & ~scl_d;
    assign start_evt = scl_v & scl_d & sda_d & ~sda_v;
    assign stop_evt  = scl_v & scl_d & ~sda_d & sda_v;

    state_e     state_q, state_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic [7:0] shift_q, shift_d;
    logic       first_q, first_d;
    logic       partial_q, partial_d;
    logic       busy_d;
    logic       rec_evt, frag_evt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            bitcnt_q  <= '0;
            shift_q   <= '0;
            first_q   <= 1'b0;
            partial_q <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shift_q   <= shift_d;
            first_q   <= first_d;
            partial_q <= partial_d;
            busy      <= busy_d;
        end
    end

    // A START/STOP always follows an SCL rise that was already sampled as a bit; fragments are
    // judged by the byte state before that rise (partial_q), not by the sample it produced.
    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shift_d   = shift_q;
        first_d   = first_q;
        partial_d = partial_q;
        busy_d    = busy;
        rec_evt   = 1'b0;
        frag_evt  = 1'b0;
        if (stop_evt) begin
            state_d   = StIdle;
            bitcnt_d  = '0;
            busy_d    = 1'b0;
            frag_evt  = partial_q;
            partial_d = 1'b0;
        end else if (start_evt) begin
            state_d   = StData;
            bitcnt_d  = '0;
            first_d   = 1'b1;
            busy_d    = 1'b1;
            frag_evt  = partial_q;
            partial_d = 1'b0;
        end else if (rise) begin
            partial_d = (bitcnt_q != 3'd0) || (state_q == StAck);
            unique case (state_q)
                StData: begin
                    shift_d  = {shift_q[6:0], sda_v};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = StAck;
                end
                StAck: begin
                    rec_evt  = 1'b1;
                    first_d  = 1'b0;
                    bitcnt_d = '0;
                    state_d  = StData;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            wr_tag    <= '0;
            full      <= 1'b0;
            start_cnt <= '0;
            stop_cnt  <= '0;
            frag_cnt  <= '0;
        end else begin
            wr_en <= rec_evt & ~full;
            if (rec_evt) begin
                wr_data <= shift_q;
                wr_tag  <= {first_q, sda_v};
            end
            if (clr) begin
                wr_addr   <= '0;
                full      <= 1'b0;
                start_cnt <= '0;
                stop_cnt  <= '0;
                frag_cnt  <= '0;
            end else begin
                if (wr_en) begin
                    if (wr_addr == {AW{1'b1}}) full <= 1'b1;
                    else                       wr_addr <= wr_addr + 1'b1;
                end
                if (start_evt) start_cnt <= start_cnt + 1'b1;
                if (stop_evt)  stop_cnt  <= stop_cnt + 1'b1;
                if (frag_evt && frag_cnt != 8'hFF) frag_cnt <= frag_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_i2c_frame_decoder.sv
// Scoreboard bench for i2c_frame_decoder: bus-level stimulus, expected records queued by a
// transaction model, a monitor pops them on every wr_en.
`timescale 1ns/1ps
module tb_i2c_frame_decoder;

    localparam int unsigned AW    = 2;
    localparam int unsigned CNT_W = 16;
    localparam int          MAXA  = (1 << AW) - 1;

    logic             clk = 1'b0;
    logic             rst, scl, sda, clr;
    logic             wr_en, full, busy;
    logic [AW-1:0]    wr_addr;
    logic [7:0]       wr_data, frag_cnt;
    logic [1:0]       wr_tag;
    logic [CNT_W-1:0] start_cnt, stop_cnt;

    i2c_frame_decoder #(.AW(AW), .CNT_W(CNT_W), .FILT_LEN(3)) dut (
        .clk(clk), .rst(rst), .scl(scl), .sda(sda), .clr(clr),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_tag(wr_tag),
        .full(full), .busy(busy), .start_cnt(start_cnt), .stop_cnt(stop_cnt),
        .frag_cnt(frag_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
        logic [1:0]    tag;
    } rec_t;

    rec_t exp_q[$];
    rec_t got;
    int   n_cmp = 0;
    int   n_err = 0;
    int   q = 4;

    // Transaction-level model of the bus as the analyzer should see it.
    int         m_start, m_stop, m_frag, m_ptr, m_bits;
    bit         m_full, m_busy, m_first, m_partial;
    logic [7:0] m_byte;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_write: got addr %0d data %02h, expected no write",
                         wr_addr, wr_data);
            end else begin
                got = exp_q.pop_front();
                check("wr_addr", 32'(wr_addr), 32'(got.addr));
                check("wr_data", 32'(wr_data), 32'(got.data));
                check("wr_tag",  32'(wr_tag),  32'(got.tag));
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_start = 0; m_stop = 0; m_frag = 0; m_ptr = 0; m_bits = 0;
        m_full = 0; m_busy = 0; m_first = 0; m_partial = 0; m_byte = '0;
    endtask

    // Every SCL rise is a bit sample; the 9th of a byte closes it as a record.
    task automatic model_rise(input bit b);
        m_partial = m_busy && (m_bits != 0);
        if (m_busy) begin
            if (m_bits == 8) begin
                if (!m_full) begin
                    exp_q.push_back('{addr: AW'(m_ptr), data: m_byte, tag: {m_first, b}});
                    if (m_ptr == MAXA) m_full = 1;
                    else m_ptr++;
                end
                m_first = 0;
                m_bits  = 0;
            end else begin
                m_byte = {m_byte[6:0], b};
                m_bits++;
            end
        end
    endtask

    task automatic model_frag();
        if (m_partial && m_frag < 255) m_frag++;
        m_partial = 0;
        m_bits    = 0;
    endtask

    task automatic bus_start();
        if (scl == 1'b0) begin
            sda = 1'b1; wait_clk(q);
            scl = 1'b1; model_rise(1'b1); wait_clk(q);
        end
        sda = 1'b0;
        model_frag();
        m_start++; m_busy = 1; m_first = 1;
        wait_clk(q);
        scl = 1'b0; wait_clk(q);
    endtask

    task automatic bus_stop();
        if (scl == 1'b1) begin
            scl = 1'b0; wait_clk(q);
        end
        sda = 1'b0; wait_clk(q);
        scl = 1'b1; model_rise(1'b0); wait_clk(q);
        sda = 1'b1;
        model_frag();
        m_stop++; m_busy = 0;
        wait_clk(q);
    endtask

    task automatic send_bit(input bit b);
        sda = b; wait_clk(q);
        scl = 1'b1; model_rise(b); wait_clk(2 * q);
        scl = 1'b0; wait_clk(q);
    endtask

    task automatic send_byte(input logic [7:0] d, input bit nack);
        for (int i = 7; i >= 0; i--) send_bit(d[i]);
        send_bit(nack);
    endtask

    task automatic check_state(input string tag);
        wait_clk(10);
        check({tag, ".start_cnt"}, 32'(start_cnt), 32'(m_start));
        check({tag, ".stop_cnt"},  32'(stop_cnt),  32'(m_stop));
        check({tag, ".frag_cnt"},  32'(frag_cnt),  32'(m_frag));
        check({tag, ".full"},      32'(full),      32'(m_full));
        check({tag, ".busy"},      32'(busy),      32'(m_busy));
        check({tag, ".wr_addr"},   32'(wr_addr),   32'(m_ptr));
        check({tag, ".pending"},   32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_clr();
        clr = 1'b1; wait_clk(1);
        clr = 1'b0;
        m_start = 0; m_stop = 0; m_frag = 0; m_ptr = 0; m_full = 0;
        wait_clk(1);
    endtask

    initial begin
        int nb, nf;
        scl = 1'b1; sda = 1'b1; clr = 1'b0; rst = 1'b1;
        model_reset();
        wait_clk(4);
        rst = 1'b0;
        wait_clk(1);
        check("reset.wr_en", 32'(wr_en), 32'd0);
        check_state("reset");

        bus_start(); send_byte(8'hA0, 1'b0); send_byte(8'h5A, 1'b1); bus_stop();
        check_state("t1");
        do_clr();

        bus_start(); send_byte(8'h90, 1'b0);
        bus_start(); send_byte(8'h91, 1'b0); send_byte(8'h33, 1'b1); bus_stop();
        check_state("t2");
        do_clr();

        bus_start();
        for (int i = 0; i < 5; i++) send_bit(1'(i));
        bus_stop();
        check_state("t3");

        do_clr();
        bus_start();
        check_state("t4_mid");
        for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i), 1'b0);
        bus_stop();
        check_state("t4_full");
        do_clr();
        check_state("t4_clr");

        bus_start();
        for (int i = 0; i < 4; i++) send_bit(1'(i));
        rst = 1'b1; wait_clk(3);
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        sda = 1'b1; wait_clk(q);
        scl = 1'b1; wait_clk(2 * q);
        bus_start(); send_byte(8'h55, 1'b0); bus_stop();
        check_state("t5");
        do_clr();

`ifdef I2CD_GLITCH_FILTER_EN
        bus_start();
        sda = 1'b1; wait_clk(q);
        scl = 1'b1; wait_clk(2);
        scl = 1'b0; wait_clk(q);
        send_byte(8'hA0, 1'b0); send_byte(8'h5A, 1'b1); bus_stop();
        check_state("t6_glitch");
        do_clr();
`endif

        for (int it = 0; it < 20; it++) begin
            q = $urandom_range(3, 6);
            if ($urandom_range(0, 5) == 0) bus_stop();
            bus_start();
            nb = $urandom_range(1, 3);
            for (int b = 0; b < nb; b++) begin
                if (b > 0 && $urandom_range(0, 3) == 0) bus_start();
                send_byte(8'($urandom), 1'($urandom));
            end
            if ($urandom_range(0, 2) == 0) begin
                nf = $urandom_range(1, 8);
                for (int k = 0; k < nf; k++) send_bit(1'($urandom));
                if ($urandom_range(0, 1) == 0) bus_start();
            end
            bus_stop();
            check_state("rand");
            if ($urandom_range(0, 3) == 0) do_clr();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
